// File: rtl/seg_display_arb_pkg.sv
// Shared constants and state type for the time-shared hex display arbiter.
package seg_display_arb_pkg;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

endpackage

// File: rtl/seg_display_arb_rr_pick4.sv
// Combinational 4-way round-robin search: first asserted request at or after rr.
module rr_pick4
(
    input  logic [3:0] req,
    input  logic [1:0] rr,
    output logic       any,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk from the farthest slot back to rr so the nearest hit is assigned last.
    always_comb begin
        any  = 1'b0;
        idx  = 2'd0;
        cand = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = rr + 2'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/seg_display_arb.sv
// Round-robin owner of the 8-digit hex display with per-owner dwell time;
// also generates the digit scan, and swaps data only at frame boundaries.
module seg_display_arb
    import seg_display_arb_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DWELL    = 64
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]       disp_data,
    output logic                    disp_blank,
    output logic [2:0]              digit_sel,
    output logic                    scan_tick
);

    localparam int SC_W = $clog2(SCAN_DIV);
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [SC_W-1:0]   sc;
    logic [1:0]        rr, rr_next;
    logic [DW_W-1:0]   dwell, dwell_next;
    arb_state_t        state, state_next;
    logic [N_REQ-1:0]  gnt_next;
    logic [DATA_W-1:0] data_next;
    logic              blank_next;
    logic              frame_end;
    logic              pick_any;
    logic [1:0]        pick_idx;
    logic [1:0]        owner_idx;
    logic              owner_req;
    logic              others_req;
    logic              grant_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc        <= '0;
            scan_tick <= 1'b0;
            digit_sel <= 3'd0;
        end else begin
            scan_tick <= (sc == SC_W'(SCAN_DIV - 1));
            sc        <= (sc == SC_W'(SCAN_DIV - 1)) ? '0 : sc + SC_W'(1);
            if (scan_tick)
                digit_sel <= digit_sel + 3'd1;
        end
    end

    assign frame_end = scan_tick && (digit_sel == 3'd7);

    rr_pick4 u_pick (
        .req (req),
        .rr  (rr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        owner_idx = 2'd0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt[i])
                owner_idx = 2'(i);
    end

    assign owner_req  = |(req & gnt);
    assign others_req = |(req & ~gnt);

    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        data_next  = disp_data;
        blank_next = disp_blank;
        rr_next    = rr;
        dwell_next = dwell;
        grant_new  = 1'b0;
        if (frame_end) begin
            unique case (state)
                IDLE: grant_new = pick_any;
                HOLD: begin
                    if (!owner_req) begin
                        if (others_req) begin
                            grant_new = 1'b1;
                        end else begin
                            gnt_next   = '0;
                            blank_next = 1'b1;
                            state_next = IDLE;
                        end
                    end else if (dwell != '0) begin
                        dwell_next = dwell - DW_W'(1);
                        data_next  = req_data[int'(owner_idx)*DATA_W +: DATA_W];
                    end else if (others_req) begin
                        grant_new = 1'b1;
                    end else begin
                        data_next = req_data[int'(owner_idx)*DATA_W +: DATA_W];
                    end
                end
                default: state_next = IDLE;
            endcase
            // rr sits just past the owner, so the search only returns the owner last.
            if (grant_new) begin
                gnt_next   = N_REQ'(1) << pick_idx;
                data_next  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                blank_next = 1'b0;
                dwell_next = DW_W'(DWELL - 1);
                rr_next    = pick_idx + 2'd1;
                state_next = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            disp_data  <= '0;
            disp_blank <= 1'b1;
            rr         <= 2'd0;
            dwell      <= '0;
        end else begin
            state      <= state_next;
            gnt        <= gnt_next;
            disp_data  <= data_next;
            disp_blank <= blank_next;
            rr         <= rr_next;
            dwell      <= dwell_next;
        end
    end

endmodule

// File: tb/tb_seg_display_arb.sv
// Self-checking bench for seg_display_arb with a frame-level behavioural model.
module tb_seg_display_arb;

    localparam int SD    = 4;
    localparam int DW    = 2;
    localparam int FRAME = 8 * SD;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req;
    logic [31:0]  words [4];
    logic [127:0] req_data;
    logic [3:0]   gnt;
    logic [31:0]  disp_data;
    logic         disp_blank;
    logic [2:0]   digit_sel;
    logic         scan_tick;

    int checks = 0;
    int errors = 0;

    assign req_data = {words[3], words[2], words[1], words[0]};

    seg_display_arb #(.SCAN_DIV(SD), .DWELL(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .disp_data  (disp_data),
        .disp_blank (disp_blank),
        .digit_sel  (digit_sel),
        .scan_tick  (scan_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycle count since release, owner index and frames owned so far.
    int          m_n;
    int          m_owner;
    int          m_held;
    int          m_rr;
    int          m_win;
    logic [3:0]  m_gnt;
    logic [31:0] m_data;
    logic        m_blank;
    logic [3:0]  m_others;

    function automatic int rr_search(input logic [3:0] r, input int from);
        for (int k = 0; k < 4; k++)
            if (r[(from + k) % 4]) return (from + k) % 4;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_owner = -1; m_held = 0; m_rr = 0;
            m_gnt = 4'b0; m_data = 32'h0; m_blank = 1'b1;
        end else begin
            m_n++;
            if (m_n > FRAME && (m_n - 1) % FRAME == 0) begin
                m_win    = -1;
                m_others = (m_owner >= 0) ? (req & ~(4'b0001 << m_owner)) : req;
                if (m_owner < 0) begin
                    m_win = rr_search(req, m_rr);
                end else if (!req[m_owner]) begin
                    m_win = rr_search(m_others, m_rr);
                    if (m_win < 0) begin
                        m_owner = -1; m_gnt = 4'b0; m_blank = 1'b1;
                    end
                end else if (m_held >= DW && m_others != 4'b0) begin
                    m_win = rr_search(m_others, m_rr);
                end else begin
                    if (m_held < DW) m_held++;
                    m_data = words[m_owner];
                end
                if (m_win >= 0) begin
                    m_owner = m_win; m_held = 1; m_rr = (m_win + 1) % 4;
                    m_gnt = 4'b0001 << m_win; m_data = words[m_win]; m_blank = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0;
        for (int i = 0; i < 4; i++) words[i] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        repeat (3) @(negedge clk);
        checks += 5;
        if (gnt !== 4'b0) begin errors++; $display("[TB] FAIL reset_gnt got %b want 0000", gnt); end
        if (disp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h want 00000000", disp_data); end
        if (disp_blank !== 1'b1) begin errors++; $display("[TB] FAIL reset_blank got %b want 1", disp_blank); end
        if (digit_sel !== 3'd0) begin errors++; $display("[TB] FAIL reset_digit got %0d want 0", digit_sel); end
        if (scan_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got %b want 0", scan_tick); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        int n;
        do_reset();
        for (n = 1; n <= 2 * FRAME + 4; n++) begin
            @(negedge clk);
            checks += 4;
            if (scan_tick !== ((n % SD) == 0)) begin errors++; $display("[TB] FAIL idle_tick n=%0d got %b want %b", n, scan_tick, (n % SD) == 0); end
            if (digit_sel !== 3'(((n - 1) / SD) % 8)) begin errors++; $display("[TB] FAIL idle_digit n=%0d got %0d want %0d", n, digit_sel, ((n - 1) / SD) % 8); end
            if (gnt !== 4'b0) begin errors++; $display("[TB] FAIL idle_gnt n=%0d got %b want 0000", n, gnt); end
            if (disp_blank !== 1'b1) begin errors++; $display("[TB] FAIL idle_blank n=%0d got %b want 1", n, disp_blank); end
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        repeat (10) @(negedge clk);
        words[2] = 32'hDEADBEEF;
        req      = 4'b0100;
        repeat (22) @(negedge clk);
        checks += 2;
        if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL single_early_gnt got %b want 0000", gnt); end
        if (disp_blank !== 1'b1) begin errors++; $display("[TB] FAIL single_early_blank got %b want 1", disp_blank); end
        @(negedge clk);
        checks += 3;
        if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL single_gnt got %b want 0100", gnt); end
        if (disp_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_data got %h want deadbeef", disp_data); end
        if (disp_blank !== 1'b0) begin errors++; $display("[TB] FAIL single_blank got %b want 0", disp_blank); end
    endtask

    task automatic test_rotation();
        logic [3:0] seq [7];
        seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        req = 4'b1011;
        repeat (FRAME) @(negedge clk);
        for (int f = 1; f <= 7; f++) begin
            @(negedge clk);
            checks += 2;
            if (gnt !== seq[f - 1]) begin errors++; $display("[TB] FAIL rotate_gnt frame=%0d got %b want %b", f, gnt, seq[f - 1]); end
            if (disp_data !== m_data) begin errors++; $display("[TB] FAIL rotate_data frame=%0d got %h want %h", f, disp_data, m_data); end
            repeat (FRAME - 1) @(negedge clk);
        end
    endtask

    task automatic test_midframe_data();
        do_reset();
        words[0] = 32'h12345678;
        req      = 4'b0001;
        repeat (45) @(negedge clk);
        words[0] = 32'hCAFEF00D;
        repeat (19) @(negedge clk);
        checks += 1;
        if (disp_data !== 32'h12345678) begin errors++; $display("[TB] FAIL midframe_hold got %h want 12345678", disp_data); end
        @(negedge clk);
        checks += 2;
        if (disp_data !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL midframe_update got %h want cafef00d", disp_data); end
        if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL midframe_gnt got %b want 0001", gnt); end
    endtask

    task automatic test_drop();
        do_reset();
        words[1] = 32'hA5A50001;
        req      = 4'b0010;
        repeat (40) @(negedge clk);
        req      = 4'b0000;
        words[1] = 32'h0BADF00D;
        repeat (24) @(negedge clk);
        checks += 1;
        if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL drop_early_gnt got %b want 0010", gnt); end
        @(negedge clk);
        checks += 3;
        if (gnt !== 4'b0000) begin errors++; $display("[TB] FAIL drop_gnt got %b want 0000", gnt); end
        if (disp_blank !== 1'b1) begin errors++; $display("[TB] FAIL drop_blank got %b want 1", disp_blank); end
        if (disp_data !== 32'hA5A50001) begin errors++; $display("[TB] FAIL drop_data got %h want a5a50001", disp_data); end
    endtask

    task automatic test_async_reset();
        do_reset();
        words[2] = 32'h55AA55AA;
        req      = 4'b0100;
        repeat (50) @(negedge clk);
        checks += 1;
        if (gnt !== 4'b0100) begin errors++; $display("[TB] FAIL async_pre_gnt got %b want 0100", gnt); end
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (gnt !== 4'b0) begin errors++; $display("[TB] FAIL async_gnt got %b want 0000", gnt); end
        if (disp_data !== 32'h0) begin errors++; $display("[TB] FAIL async_data got %h want 00000000", disp_data); end
        if (disp_blank !== 1'b1) begin errors++; $display("[TB] FAIL async_blank got %b want 1", disp_blank); end
        if (digit_sel !== 3'd0) begin errors++; $display("[TB] FAIL async_digit got %0d want 0", digit_sel); end
        if (scan_tick !== 1'b0) begin errors++; $display("[TB] FAIL async_tick got %b want 0", scan_tick); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        for (int c = 0; c < 24 * FRAME; c++) begin
            @(negedge clk);
            checks += 5;
            if (gnt !== m_gnt) begin errors++; $display("[TB] FAIL rand_gnt n=%0d got %b want %b", m_n, gnt, m_gnt); end
            if (disp_data !== m_data) begin errors++; $display("[TB] FAIL rand_data n=%0d got %h want %h", m_n, disp_data, m_data); end
            if (disp_blank !== m_blank) begin errors++; $display("[TB] FAIL rand_blank n=%0d got %b want %b", m_n, disp_blank, m_blank); end
            if (scan_tick !== (m_n >= SD && m_n % SD == 0)) begin errors++; $display("[TB] FAIL rand_tick n=%0d got %b", m_n, scan_tick); end
            if (digit_sel !== 3'((m_n == 0) ? 0 : ((m_n - 1) / SD) % 8)) begin errors++; $display("[TB] FAIL rand_digit n=%0d got %0d", m_n, digit_sel); end
            if ($urandom_range(0, 23) == 0 || (m_n % FRAME == 0 && $urandom_range(0, 2) == 0))
                req = 4'($urandom);
            if ($urandom_range(0, 5) == 0)
                words[$urandom_range(0, 3)] = $urandom;
        end
    endtask

    initial begin
        test_reset();
        test_idle_scan();
        test_single_grant();
        test_rotation();
        test_midframe_data();
        test_drop();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
